// File: rtl/scpad_requester.sv
// Scratchpad tile requester: expands a tile command into row requests, bounds the number
// of requests in flight and forwards in-order read responses to the consumer.
module scpad_requester #(
    parameter int unsigned NUM_COLS  = 32,
    parameter int unsigned ELEM_BITS = 16,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [ADDR_W-1:0]               cmd_base_i,
    input  logic [ADDR_W-1:0]               cmd_rows_i,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [NUM_COLS*ELEM_BITS-1:0]   wr_data_i,
    output logic                            req_valid_o,
    input  logic                            req_ready_i,
    output logic                            req_write_o,
    output logic [ADDR_W-1:0]               req_addr_o,
    output logic [NUM_COLS*ELEM_BITS-1:0]   req_wdata_o,
    input  logic                            rsp_valid_i,
    input  logic [NUM_COLS*ELEM_BITS-1:0]   rsp_rdata_i,
    output logic                            rd_valid_o,
    output logic [NUM_COLS*ELEM_BITS-1:0]   rd_data_o,
    output logic                            done_o
);

    localparam int unsigned OutW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   rows_q, rows_d;
    logic [ADDR_W-1:0]   issued_q, issued_d;
    logic [OutW-1:0]     out_q, out_d;

    logic req_valid;
    logic accept;
    logic rsp_ok;

    always_comb begin
        req_valid = (state_q == StIssue) && (out_q < OutW'(MAX_OUT)) &&
                    (!write_q || wr_valid_i);
        accept    = req_valid && req_ready_i;
        // Responses with nothing in flight are protocol errors and are dropped.
        rsp_ok    = rsp_valid_i && (out_q != '0);

        out_d = out_q;
        if (accept && !rsp_ok) begin
            out_d = out_q + OutW'(1);
        end else if (!accept && rsp_ok) begin
            out_d = out_q - OutW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        base_d   = base_q;
        rows_d   = rows_q;
        issued_d = issued_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    write_d  = cmd_write_i;
                    base_d   = cmd_base_i;
                    rows_d   = cmd_rows_i;
                    issued_d = '0;
                    state_d  = (cmd_rows_i == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    issued_d = issued_q + ADDR_W'(1);
                    if (issued_d == rows_q) begin
                        state_d = (out_d == '0) ? StDone : StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            base_q   <= '0;
            rows_q   <= '0;
            issued_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            base_q   <= base_d;
            rows_q   <= rows_d;
            issued_q <= issued_d;
            out_q    <= out_d;
        end
    end

    // Outputs are forced low combinationally while reset is held.
    always_comb begin
        cmd_ready_o = rst_ni && (state_q == StIdle);
        req_valid_o = rst_ni && req_valid;
        wr_ready_o  = rst_ni && accept && write_q;
        req_write_o = write_q;
        req_addr_o  = base_q + issued_q;
        req_wdata_o = rst_ni ? wr_data_i : '0;
        rd_valid_o  = rst_ni && rsp_ok && !write_q;
        rd_data_o   = rst_ni ? rsp_rdata_i : '0;
        done_o      = (state_q == StDone);
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(rsp_valid_i && (out_q == '0)));
    assert property (@(posedge clk_i) disable iff (!rst_ni) out_q <= OutW'(MAX_OUT));

endmodule
